// File: rtl/fifo_serial_tx.sv
// ---------------------------------------------------------------------------
// fifo_serial_tx
//
// Pops words from an upstream FIFO and sends each one as an asynchronous
// serial frame: start bit (0), BITS data bits LSB first, an optional even
// parity bit, and one stop bit (1). Every bit lasts CLKS_PER_BIT clocks.
//
// Parameters
//   BITS          word width popped from the FIFO (>= 2)
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   PARITY_EN     1 = even parity bit present, 0 = no parity bit
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous, active-low reset
//   enable       permits new frames to start (never aborts a frame)
//   fifo_ready   upstream FIFO holds at least one word
//   fifo_data    upstream FIFO head word
//   fifo_read    pop strobe, high for the single LOAD cycle of each frame
//   tx           registered serial line, idle high
//   busy         high whenever the FSM is not in IDLE
//   frame_done   one-cycle pulse in the first IDLE cycle after STOP
//   frame_count  number of completed frames, wraps at 16 bits
//
// Timing: tx is registered from the current state, so the line trails the
// FSM by one clock. A frame accepted at edge N is in LOAD for cycle N..N+1,
// enters START at N+1 and drives the start bit from edge N+2. Back-to-back
// frames therefore see exactly two idle-high cycles (IDLE + LOAD) between
// the end of the stop bit and the next start bit.
// ---------------------------------------------------------------------------
module fifo_serial_tx #(
    parameter int BITS         = 12,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            fifo_ready,
    input  logic [BITS-1:0] fifo_data,
    output logic            fifo_read,
    output logic            tx,
    output logic            busy,
    output logic            frame_done,
    output logic [15:0]     frame_count
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (BITS > 1) ? $clog2(BITS) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    state_t             state_reg;
    logic [BAUD_W-1:0]  baud_reg;
    logic [BIT_W-1:0]   bit_reg;
    logic [BITS-1:0]    shift_reg;
    logic               parity_reg;
    logic               tx_reg;
    logic               frame_done_reg;
    logic [15:0]        frame_count_reg;
    // Set by the first clock edge after reset release; holds off LOAD so the
    // first pop cannot happen before the second rising edge.
    logic               armed_reg;

    logic               baud_last;
    logic [BITS:0]      par_chain;

    // Even parity of the FIFO head word as an XOR chain; only sampled at
    // the LOAD-exit edge together with the word itself.
    assign par_chain[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < BITS; gi++) begin : g_parity
            assign par_chain[gi+1] = par_chain[gi] ^ fifo_data[gi];
        end
    endgenerate

    assign baud_last = (baud_reg == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            baud_reg        <= '0;
            bit_reg         <= '0;
            shift_reg       <= '0;
            parity_reg      <= 1'b0;
            tx_reg          <= 1'b1;
            frame_done_reg  <= 1'b0;
            frame_count_reg <= 16'h0000;
            armed_reg       <= 1'b0;
        end else begin
            armed_reg      <= 1'b1;
            frame_done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    tx_reg   <= 1'b1;
                    baud_reg <= '0;
                    bit_reg  <= '0;
                    if (armed_reg && enable && fifo_ready) begin
                        state_reg <= LOAD;
                    end
                end

                // The pop strobe is high during this cycle; the word is
                // captured on the edge that leaves LOAD, whatever fifo_ready
                // says at that moment.
                LOAD: begin
                    tx_reg     <= 1'b1;
                    shift_reg  <= fifo_data;
                    parity_reg <= par_chain[BITS];
                    baud_reg   <= '0;
                    bit_reg    <= '0;
                    state_reg  <= START;
                end

                START: begin
                    tx_reg <= 1'b0;
                    if (baud_last) begin
                        baud_reg  <= '0;
                        state_reg <= DATA;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end

                // tx takes the current LSB; the shift happens on the edge
                // that closes the bit, so the next bit appears one clock
                // later in lockstep with the rest of the line timing.
                DATA: begin
                    tx_reg <= shift_reg[0];
                    if (baud_last) begin
                        baud_reg  <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_reg == BIT_LAST) begin
                            bit_reg   <= '0;
                            state_reg <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_reg <= bit_reg + 1'b1;
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end

                PARITY: begin
                    tx_reg <= parity_reg;
                    if (baud_last) begin
                        baud_reg  <= '0;
                        state_reg <= STOP;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end

                STOP: begin
                    tx_reg <= 1'b1;
                    if (baud_last) begin
                        baud_reg        <= '0;
                        state_reg       <= IDLE;
                        frame_done_reg  <= 1'b1;
                        frame_count_reg <= frame_count_reg + 16'd1;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end

                default: begin
                    tx_reg    <= 1'b1;
                    baud_reg  <= '0;
                    bit_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Pure state decodes: they follow the asynchronous reset instantly.
    assign fifo_read   = (state_reg == LOAD);
    assign busy        = (state_reg != IDLE);
    assign tx          = tx_reg;
    assign frame_done  = frame_done_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_fifo_serial_tx.sv
module tb_fifo_serial_tx;

    localparam int BITS = 12;
    localparam int CPB  = 4;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        fifo_ready;
    logic [11:0] fifo_data;
    logic        fifo_read;
    logic        tx;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;

    logic        np_enable;
    logic        np_ready;
    logic [11:0] np_data;
    logic        np_read;
    logic        np_tx;
    logic        np_busy;
    logic        np_done;
    logic [15:0] np_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_count[2];

    logic [11:0] fifo_q[$];   // upstream FIFO contents
    logic [11:0] sb_q[$];     // words expected on the line, in order

    fifo_serial_tx #(.BITS(BITS), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_ready(fifo_ready),
        .fifo_data(fifo_data), .fifo_read(fifo_read), .tx(tx), .busy(busy),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    fifo_serial_tx #(.BITS(BITS), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut_np (
        .clk(clk), .rst_n(rst_n), .enable(np_enable), .fifo_ready(np_ready),
        .fifo_data(np_data), .fifo_read(np_read), .tx(np_tx), .busy(np_busy),
        .frame_done(np_done), .frame_count(np_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream FIFO: pops on a sampled strobe; head is garbage when empty so
    // that data changes outside LOAD are exercised.
    always @(posedge clk) begin
        if (fifo_read && fifo_q.size() > 0) void'(fifo_q.pop_front());
        #1;
        if (fifo_q.size() > 0) begin
            fifo_ready = 1'b1;
            fifo_data  = fifo_q[0];
        end else begin
            fifo_ready = 1'b0;
            fifo_data  = 12'($urandom);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] line_obs(input bit np);
        return np ? {np_tx, np_done, np_read} : {tx, frame_done, fifo_read};
    endfunction

    function automatic logic rd(input bit np);
        return np ? np_read : fifo_read;
    endfunction

    // Waits (bounded) for the pop strobe, then checks every clock of the
    // frame against the frame built from the word's bits.
    task automatic check_frame(input bit np, input logic [11:0] word,
                               input int max_wait, output int waited);
        logic exp_bits[$];
        int   nb;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < BITS; i++) exp_bits.push_back(((word >> i) & 12'd1) != 0);
        if (!np) exp_bits.push_back(($countones(word) % 2) == 1);
        exp_bits.push_back(1'b1);
        nb = exp_bits.size();

        waited = 0;
        while (!rd(np) && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("pop strobe np=%0d", np), {31'd0, rd(np)}, 32'd1);
        if (!rd(np)) return;
        check("LOAD cycle line/done/read", {29'd0, line_obs(np)}, 32'b101);
        check("busy in LOAD", {31'd0, np ? np_busy : busy}, 32'd1);
        @(negedge clk);
        check("START state line still idle", {29'd0, line_obs(np)}, 32'b100);
        for (int k = 0; k < nb; k++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                check($sformatf("frame %03h bit %0d clk %0d", word, k, c),
                      {29'd0, line_obs(np)},
                      {29'd0, exp_bits[k], (k == nb - 1 && c == CPB - 1), 1'b0});
            end
        end
        exp_count[np]++;
        check("frame_count", {16'd0, np ? np_count : frame_count},
              32'(exp_count[np]) & 32'hFFFF);
        $display("frame np=%0d word=%03h waited=%0d count=%0d cycles=%0d",
                 np, word, waited, exp_count[np], nb * CPB);
    endtask

    initial begin
        int w;
        logic [11:0] words[3];
        exp_count[0] = 0;
        exp_count[1] = 0;
        rst_n = 1'b1; enable = 1'b0; fifo_ready = 1'b0; fifo_data = '0;
        np_enable = 1'b0; np_ready = 1'b0; np_data = '0;
        #1 rst_n = 1'b0;
        #1;
        check("reset tx/busy/read/done", {28'd0, tx, busy, fifo_read, frame_done}, 32'b1000);
        check("reset frame_count", {16'd0, frame_count}, 32'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Single directed word.
        enable = 1'b1;
        fifo_q.push_back(12'hA5C); sb_q.push_back(12'hA5C);
        check_frame(0, sb_q.pop_front(), 20, w);
        @(negedge clk);
        check("idle after single frame", {30'd0, busy, fifo_read}, 32'd0);

        // Back-to-back directed words with distinct parity.
        words[0] = 12'h001; words[1] = 12'hFFF; words[2] = 12'h800;
        for (int i = 0; i < 3; i++) begin
            fifo_q.push_back(words[i]); sb_q.push_back(words[i]);
        end
        for (int i = 0; i < 3; i++) begin
            check_frame(0, sb_q.pop_front(), 20, w);
            if (i > 0) check("back-to-back gap", 32'(w), 32'd1);
        end

        // Random single words with the FIFO empty in between.
        for (int i = 0; i < 4; i++) begin
            logic [11:0] r;
            r = 12'($urandom);
            fifo_q.push_back(r); sb_q.push_back(r);
            check_frame(0, sb_q.pop_front(), 20, w);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Random back-to-back burst.
        for (int i = 0; i < 3; i++) begin
            logic [11:0] r;
            r = 12'($urandom);
            fifo_q.push_back(r); sb_q.push_back(r);
        end
        for (int i = 0; i < 3; i++) begin
            check_frame(0, sb_q.pop_front(), 20, w);
            if (i > 0) check("random burst gap", 32'(w), 32'd1);
        end

        // enable dropped mid-frame: frame completes, nothing more is popped.
        for (int i = 0; i < 2; i++) begin
            logic [11:0] r;
            r = 12'($urandom);
            fifo_q.push_back(r); sb_q.push_back(r);
        end
        fork
            check_frame(0, sb_q.pop_front(), 20, w);
            begin
                repeat (20) @(negedge clk);
                enable = 1'b0;
            end
        join
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("held off by enable=0", {30'd0, fifo_read, busy}, 32'd0);
        end
        #1 enable = 1'b1;
        check_frame(0, sb_q.pop_front(), 20, w);
        check("LOAD right after enable", 32'(w), 32'd1);

        // Reset during data bit 5: popped word lost, next word sent whole.
        for (int i = 0; i < 2; i++) begin
            logic [11:0] r;
            r = 12'($urandom);
            fifo_q.push_back(r); sb_q.push_back(r);
        end
        for (int i = 0; i < 30 && !fifo_read; i++) @(negedge clk);
        check("pop before reset", {31'd0, fifo_read}, 32'd1);
        void'(sb_q.pop_front());
        repeat (1 + CPB + 5 * CPB + 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset outputs", {28'd0, tx, busy, fifo_read, frame_done}, 32'b1000);
        check("async reset count", {16'd0, frame_count}, 32'd0);
        exp_count[0] = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no frame_done in reset", {31'd0, frame_done}, 32'd0);
        end
        #1 rst_n = 1'b1;
        check_frame(0, sb_q.pop_front(), 20, w);
        check("first LOAD on second edge", 32'(w), 32'd2);

        // No-parity instance.
        @(negedge clk);
        #1;
        np_data = 12'h3C3; np_ready = 1'b1; np_enable = 1'b1;
        fork
            check_frame(1, 12'h3C3, 20, w);
            begin
                for (int i = 0; i < 30 && !np_read; i++) @(negedge clk);
                @(negedge clk);
                np_ready = 1'b0;
                np_data  = 12'($urandom);
            end
        join
        repeat (6) @(negedge clk);
        check("np single frame only", {30'd0, np_busy, np_read}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
